// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer: FSM state encoding and the
// bit layout of a song ROM word.
package song_sequencer_pkg;

  localparam int WORD_WIDTH = 16;

  localparam int STEREO_MSB   = 15;
  localparam int STEREO_LSB   = 14;
  localparam int NOTE_MSB     = 13;
  localparam int NOTE_LSB     = 8;
  localparam int DUR_MSB      = 7;
  localparam int DUR_LSB      = 2;
  localparam int END_BIT      = 1;
  localparam int RESERVED_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_LOAD,
    ST_WAIT_DONE,
    ST_SONG_END
  } state_t;

endpackage

// File: rtl/song_word_decoder.sv
// Splits one song ROM word into its note, duration, stereo and end-marker fields.
module song_word_decoder
  import song_sequencer_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] rom_data,
  output logic [1:0]            stereo,
  output logic [5:0]            note,
  output logic [5:0]            duration,
  output logic                  end_flag
);

  logic unused_reserved;

  assign stereo          = rom_data[STEREO_MSB:STEREO_LSB];
  assign note            = rom_data[NOTE_MSB:NOTE_LSB];
  assign duration        = rom_data[DUR_MSB:DUR_LSB];
  assign end_flag        = rom_data[END_BIT];
  assign unused_reserved = rom_data[RESERVED_BIT];

endmodule

// File: rtl/song_sequencer.sv
// Walks a song ROM, decodes each word and hands it to note_player through a
// load strobe / done handshake; handles pause, end markers, wrap and song change.
module song_sequencer #(
  parameter int SONG_BITS  = 2,
  parameter int INDEX_BITS = 5,
  parameter int WORD_WIDTH = song_sequencer_pkg::WORD_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            play,
  input  logic [SONG_BITS-1:0]            song,
  output logic [SONG_BITS+INDEX_BITS-1:0] rom_addr,
  input  logic [WORD_WIDTH-1:0]           rom_data,
  output logic [5:0]                      note_to_load,
  output logic [5:0]                      duration_to_load,
  output logic [1:0]                      stereo_side_to_load,
  output logic                            load_new_note,
  input  logic                            note_done,
  output logic                            song_done
);
  import song_sequencer_pkg::*;

  state_t                state, state_nxt;
  logic [INDEX_BITS-1:0] index, index_nxt;
  logic [SONG_BITS-1:0]  song_q, song_q_nxt;
  logic                  play_q;
  logic                  song_change;
  logic                  latch_fields;

  logic [1:0] dec_stereo;
  logic [5:0] dec_note;
  logic [5:0] dec_dur;
  logic       dec_end;

  song_word_decoder u_decoder (
    .rom_data (rom_data),
    .stereo   (dec_stereo),
    .note     (dec_note),
    .duration (dec_dur),
    .end_flag (dec_end)
  );

  // A new song selection outranks every other event once a song is running.
  assign song_change = (state != ST_IDLE) && (song != song_q);

  always_comb begin
    state_nxt    = state;
    index_nxt    = index;
    song_q_nxt   = song_q;
    latch_fields = 1'b0;
    if (song_change) begin
      song_q_nxt = song;
      index_nxt  = '0;
      state_nxt  = ST_FETCH;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (play && !play_q) begin
            song_q_nxt = song;
            index_nxt  = '0;
            state_nxt  = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (play) state_nxt = ST_DECODE;
        end
        ST_DECODE: begin
          if (dec_end) begin
            state_nxt = ST_SONG_END;
          end else begin
            latch_fields = 1'b1;
            state_nxt    = ST_LOAD;
          end
        end
        ST_LOAD: state_nxt = ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (note_done) begin
            // The last addressable word ends the song rather than wrapping.
            if (&index) begin
              state_nxt = ST_SONG_END;
            end else begin
              index_nxt = index + INDEX_BITS'(1);
              state_nxt = ST_FETCH;
            end
          end
        end
        ST_SONG_END: begin
          index_nxt = '0;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      index  <= '0;
      song_q <= '0;
      play_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      index  <= index_nxt;
      song_q <= song_q_nxt;
      play_q <= play;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      note_to_load        <= '0;
      duration_to_load    <= '0;
      stereo_side_to_load <= '0;
    end else if (latch_fields) begin
      note_to_load        <= dec_note;
      duration_to_load    <= dec_dur;
      stereo_side_to_load <= dec_stereo;
    end
  end

  assign rom_addr      = {song_q, index};
  assign load_new_note = (state == ST_LOAD);
  assign song_done     = (state == ST_SONG_END) && !song_change;

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Initiator side of the note-load handshake that note_player answers.
- Walks a song ROM word by word and decodes each word into note, duration and stereo side.
- Pulses load_new_note, then waits for done_with_note before fetching the next word.
- Handles start/pause, end-of-song markers, index wrap and song change mid-play; sits between the top-level controls/ROM and note_player.

Parameters:
SONG_BITS, 2, width of song select; number of songs = 2^SONG_BITS
INDEX_BITS, 5, note-index width; max words per song = 2^INDEX_BITS
WORD_WIDTH, 16, ROM word width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
play  in  1  high = run, low = pause
song  in  SONG_BITS  song select
rom_addr  out  SONG_BITS+INDEX_BITS  {song_q, index}; feeds a sync ROM with 1-cycle read latency
rom_data  in  WORD_WIDTH  word: [15:14] stereo, [13:8] note, [7:2] duration, [1] end flag, [0] reserved
note_to_load  out  6  decoded note
duration_to_load  out  6  decoded duration in beats
stereo_side_to_load  out  2  one-hot side(s)
load_new_note  out  1  single-cycle load strobe
note_done  in  1  done_with_note from note_player
song_done  out  1  single-cycle pulse at end of song

Behaviour:
- Clock and reset: clk is the only clock. reset is synchronous and active-high.
- Reset values: state=IDLE, index=0, song_q=0, play_q=0. All outputs are 0.
- States: IDLE, FETCH, DECODE, LOAD, WAIT_DONE, SONG_END.
- IDLE:
  - play_q registers play every cycle.
  - On a rising edge of play (play & ~play_q): song_q<=song, index<=0, go FETCH.
  - A level-high play does not restart a finished song.
- FETCH:
  - One cycle. rom_addr is stable for it.
  - If play=0, hold in FETCH.
- DECODE:
  - rom_data is valid.
  - If end flag=1: go SONG_END. Do not load the word.
  - Else latch stereo, note and duration into the output registers and go LOAD.
- LOAD:
  - load_new_note=1 for exactly this cycle; fields are already stable. Go WAIT_DONE.
  - Latency: the load strobe comes 2 cycles after FETCH entry.
  - Fields hold until the next DECODE.
- WAIT_DONE:
  - Wait for note_done=1.
  - Then, if index == all-ones, go SONG_END (wrap = end of song). Else index+1, go FETCH.
  - Pause: play=0 does not block note_done. The player itself pauses, so done arrives later.
  - note_done seen in any state other than WAIT_DONE is ignored.
- Duration 0: loaded as normal. note_player reports done within 2 cycles and the sequencer advances.
- SONG_END: song_done=1 for one cycle, index<=0, go IDLE.
- Song change: in any non-IDLE state, song != song_q means song_q<=song, index<=0, go FETCH next cycle.
  - Any pending note_done is dropped.
  - No song_done pulse.
  - The note already playing keeps sounding until the new load overrides it.
- Simultaneous events, in priority order:
  - reset > song change > note_done > play.
  - Song change in the same cycle as note_done: the song change wins.
- Reset mid-operation: next cycle is IDLE with reset values. A load_new_note in flight is cancelled.
- Arithmetic: index is INDEX_BITS wide and does not wrap silently. Its all-ones value terminates the song.

Decomposition:
- Shared package holds:
  - state encodings;
  - ROM field bit positions (STEREO_MSB/LSB, NOTE_MSB/LSB, DUR_MSB/LSB, END_BIT);
  - WORD_WIDTH.
- One natural sub-module: song_word_decoder. It is combinational, rom_data to fields plus end flag, and is reused by any future ROM dumper.
- State, index, song_q and play_q use the team's dffr/dffre flops.

Test Plan:
- Basic load: ROM song0 = [note 0x12, dur 4, stereo 2'b01], [end]. Play rises, then:
  - load_new_note pulses once, 2 cycles after FETCH entry, with 0x12/4/01.
  - note_done 10 cycles later gives song_done exactly 3 cycles after note_done.
- Pause: play=0 while in WAIT_DONE, then note_done held off 50 cycles. No second load until note_done; the next load comes 3 cycles after note_done.
- Zero duration: word with dur 0 followed by note 0x05 dur 2. Two loads occur, the second within 5 cycles of the first, with correct fields.
- Wrap: 32 words with no end flag. After the 32nd note_done, song_done pulses once, index returns to 0, and there are no further loads while play is held high.
- Song change: song 0→2 during WAIT_DONE. Next rom_addr = {2,0}, a load follows within 2 cycles, and song_done is never asserted.
- Reset mid-LOAD: load_new_note=0 and all outputs 0 the next cycle. A new play rising edge restarts at index 0.
